// File: rtl/renkon_ctrl_feed_pkg.sv
`default_nettype none
// ============================================================================
// Module      : renkon_ctrl_feed_pkg
// Description : Shared renkon sizes, memory latency and ctrl stream record.
// Revision    : 1.0 - initial release
// ============================================================================
package renkon_ctrl_feed_pkg;

  localparam int LWIDTH  = 10;
  localparam int IMGSIZE = 12;
  localparam int D_MEM   = 1;

  typedef struct packed {
    logic start;
    logic valid;
    logic stop;
  } ctrl_reg;

endpackage
`default_nettype wire

// File: rtl/renkon_ctrl_feed_if.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_bus
// Description : start/valid/stop stream towards the conv controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface ctrl_bus;

  logic start;
  logic valid;
  logic stop;

  modport master (output start, valid, stop);
  modport slave  (input  start, valid, stop);

endinterface
`default_nettype wire

// File: rtl/renkon_ctrl_feed_delay.sv
`default_nettype none
// ============================================================================
// Module      : renkon_ctrl_delay
// Description : D_MEM-stage shift register aligning ctrl and channel flags
//               with image memory read data.
// Revision    : 1.0 - initial release
// ============================================================================
module renkon_ctrl_delay
  import renkon_ctrl_feed_pkg::*;
(
  input  wire logic clk,
  input  wire logic xrst,
  input  ctrl_reg   raw,
  input  wire logic first_raw,
  input  wire logic last_raw,
  output ctrl_reg   ctrl,
  output logic      first,
  output logic      last
);

  logic [4:0] r_stage [D_MEM];

  always_ff @(posedge clk) begin
    if (xrst) begin
      for (int i = 0; i < D_MEM; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= {raw, first_raw, last_raw};
      for (int i = 1; i < D_MEM; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign {ctrl, first, last} = r_stage[D_MEM-1];

endmodule
`default_nettype wire

// File: rtl/renkon_ctrl_feed.sv
`default_nettype none
// ============================================================================
// Module      : renkon_ctrl_feed
// Description : Walks an img_size x img_size image per input channel, issuing
//               running read addresses and a latency-aligned ctrl stream.
// Revision    : 1.0 - initial release
// ============================================================================
module renkon_ctrl_feed
  import renkon_ctrl_feed_pkg::*;
(
  input  wire logic               clk,
  input  wire logic               xrst,
  input  wire logic               req,
  input  wire logic [LWIDTH-1:0]  w_img_size,
  input  wire logic [LWIDTH-1:0]  w_in_size,
  input  wire logic [IMGSIZE-1:0] w_img_offset,
  input  wire logic               ready,
  ctrl_bus.master                 out_ctrl,
  output logic [IMGSIZE-1:0]      mem_img_addr,
  output logic                    first_input,
  output logic                    last_input,
  output logic                    busy,
  output logic                    ack
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_GAP    = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t            r_state;
  logic [LWIDTH-1:0] r_x, r_y, r_ch;
  logic [LWIDTH-1:0] r_img_size, r_in_size;
  logic [LWIDTH-1:0] r_dcnt;
  logic              r_first, r_last;

  ctrl_reg w_raw;
  ctrl_reg w_ctrl;
  logic    w_x_last, w_y_last, w_zero;

  always_comb begin
    w_raw       = '0;
    w_x_last    = (r_x == r_img_size - LWIDTH'(1));
    w_y_last    = (r_y == r_img_size - LWIDTH'(1));
    w_zero      = (w_img_size == '0) || (w_in_size == '0);
    w_raw.valid = (r_state == S_STREAM);
    w_raw.start = w_raw.valid && (r_x == '0) && (r_y == '0);
    w_raw.stop  = w_raw.valid && w_x_last && w_y_last;
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_ch         <= '0;
      r_img_size   <= '0;
      r_in_size    <= '0;
      r_dcnt       <= '0;
      r_first      <= 1'b0;
      r_last       <= 1'b0;
      mem_img_addr <= '0;
      busy         <= 1'b0;
      ack          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_img_size   <= w_img_size;
            r_in_size    <= w_in_size;
            mem_img_addr <= w_img_offset;
            r_x          <= '0;
            r_y          <= '0;
            r_ch         <= '0;
            r_first      <= !w_zero;
            r_last       <= !w_zero && (w_in_size == LWIDTH'(1));
            busy         <= 1'b1;
            if (w_zero) begin
              r_state <= S_DRAIN;
              r_dcnt  <= LWIDTH'(D_MEM - 1);
              ack     <= (D_MEM == 1);
            end else begin
              r_state <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          mem_img_addr <= mem_img_addr + IMGSIZE'(1);
          if (w_raw.stop) begin
            if (r_ch == r_in_size - LWIDTH'(1)) begin
              r_state <= S_DRAIN;
              r_dcnt  <= LWIDTH'(D_MEM - 1);
              ack     <= (D_MEM == 1);
            end else begin
              // Channel flags change here so their delayed copies flip only after the out stop.
              r_ch    <= r_ch + LWIDTH'(1);
              r_x     <= '0;
              r_y     <= '0;
              r_first <= 1'b0;
              r_last  <= (r_ch + LWIDTH'(2) == r_in_size);
              r_state <= S_GAP;
            end
          end else if (w_x_last) begin
            r_x <= '0;
            r_y <= r_y + LWIDTH'(1);
          end else begin
            r_x <= r_x + LWIDTH'(1);
          end
        end
        S_GAP: begin
          if (ready) r_state <= S_STREAM;
        end
        S_DRAIN: begin
          if (r_dcnt == '0) begin
            r_state <= S_IDLE;
            ack     <= 1'b0;
            busy    <= 1'b0;
          end else begin
            r_dcnt <= r_dcnt - LWIDTH'(1);
            ack    <= (r_dcnt == LWIDTH'(1));
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  renkon_ctrl_delay u_delay (
    .clk       (clk),
    .xrst      (xrst),
    .raw       (w_raw),
    .first_raw (r_first),
    .last_raw  (r_last),
    .ctrl      (w_ctrl),
    .first     (first_input),
    .last      (last_input)
  );

  assign out_ctrl.start = w_ctrl.start;
  assign out_ctrl.valid = w_ctrl.valid;
  assign out_ctrl.stop  = w_ctrl.stop;

endmodule
`default_nettype wire

// File: tb/tb_renkon_ctrl_feed.sv
`default_nettype none
// ============================================================================
// Module      : tb_renkon_ctrl_feed
// Description : Scoreboard bench for renkon_ctrl_feed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_renkon_ctrl_feed;
  import renkon_ctrl_feed_pkg::*;

  logic               clk = 1'b0;
  logic               xrst, req, ready;
  logic [LWIDTH-1:0]  w_img_size, w_in_size;
  logic [IMGSIZE-1:0] w_img_offset, mem_img_addr;
  logic               first_input, last_input, busy, ack;

  ctrl_bus out_ctrl ();

  always #5 clk = ~clk;

  renkon_ctrl_feed dut (
    .clk          (clk),
    .xrst         (xrst),
    .req          (req),
    .w_img_size   (w_img_size),
    .w_in_size    (w_in_size),
    .w_img_offset (w_img_offset),
    .ready        (ready),
    .out_ctrl     (out_ctrl),
    .mem_img_addr (mem_img_addr),
    .first_input  (first_input),
    .last_input   (last_input),
    .busy         (busy),
    .ack          (ack)
  );

  // flags = {start, stop, first, last, ack}
  typedef struct {
    logic [IMGSIZE-1:0] addr;
    logic [4:0]         flags;
  } exp_t;

  exp_t               q[$];
  int                 gaps[$];
  int                 errors = 0;
  int                 checks = 0;
  int                 ack_count = 0;
  logic [IMGSIZE-1:0] hist [D_MEM];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    int   idle_run = 0;
    bit   prev_stop = 1'b0;
    forever begin
      @(negedge clk);
      if (xrst) begin
        prev_stop = 1'b0;
        idle_run  = 0;
      end else begin
        if (ack) ack_count++;
        if (out_ctrl.valid) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got valid with empty scoreboard at %0t", $time);
          end else begin
            e = q.pop_front();
            check("addr", 32'(hist[D_MEM-1]), 32'(e.addr));
            check("flags", {27'd0, out_ctrl.start, out_ctrl.stop, first_input, last_input, ack},
                  {27'd0, e.flags});
          end
          if (out_ctrl.start && prev_stop) gaps.push_back(idle_run);
          prev_stop = out_ctrl.stop && !ack;
          idle_run  = 0;
        end else begin
          idle_run++;
        end
      end
      for (int i = D_MEM - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = mem_img_addr;
    end
  endtask

  task automatic push_layer(input int img, input int inn, input logic [IMGSIZE-1:0] off);
    exp_t               e;
    logic [IMGSIZE-1:0] a = off;
    logic               st, sp;
    for (int c = 0; c < inn; c++)
      for (int y = 0; y < img; y++)
        for (int x = 0; x < img; x++) begin
          st      = (x == 0) && (y == 0);
          sp      = (x == img - 1) && (y == img - 1);
          e.addr  = a;
          e.flags = {st, sp, c == 0, c == inn - 1, sp && (c == inn - 1)};
          q.push_back(e);
          a = a + 1'b1;
        end
  endtask

  task automatic pulse_req();
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle", 32'(busy), 32'd0);
  endtask

  task automatic run_layer(input int img, input int inn, input logic [IMGSIZE-1:0] off);
    int a0 = ack_count;
    push_layer(img, inn, off);
    w_img_size   = LWIDTH'(img);
    w_in_size    = LWIDTH'(inn);
    w_img_offset = off;
    pulse_req();
    wait_idle();
    check("queue_drained", 32'(q.size()), 32'd0);
    check("ack_count", 32'(ack_count), 32'(a0 + 1));
  endtask

  task automatic zero_layer(input int img, input int inn);
    int a0 = ack_count;
    w_img_size = LWIDTH'(img);
    w_in_size  = LWIDTH'(inn);
    pulse_req();
    repeat (D_MEM - 1) @(posedge clk);
    @(negedge clk);
    check("zero_ack", {30'd0, ack, out_ctrl.valid}, 32'b10);
    @(negedge clk);
    check("zero_idle", {30'd0, ack, busy}, 32'd0);
    check("zero_ack_count", 32'(ack_count), 32'(a0 + 1));
  endtask

  initial begin
    int a0;
    xrst = 1'b1; req = 1'b0; ready = 1'b1;
    w_img_size = '0; w_in_size = '0; w_img_offset = '0;
    for (int i = 0; i < D_MEM; i++) hist[i] = '0;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {25'd0, out_ctrl.valid, out_ctrl.start, out_ctrl.stop,
                         first_input, last_input, busy, ack}, 32'd0);
    check("reset_addr", 32'(mem_img_addr), 32'd0);
    @(posedge clk); #1 xrst = 1'b0;

    run_layer(4, 1, 12'h100);

    gaps.delete();
    run_layer(3, 3, 12'h010);
    check("gap_count", 32'(gaps.size()), 32'd2);
    foreach (gaps[i]) check("gap_len", 32'(gaps[i]), 32'd1);

    gaps.delete();
    ready = 1'b0;
    fork
      run_layer(2, 2, 12'h080);
      begin
        int k;
        for (k = 0; k < 200; k++) begin
          @(negedge clk);
          if (out_ctrl.stop) break;
        end
        check("ch0_stop_seen", 32'(k < 200), 32'd1);
        check("gap_addr", 32'(mem_img_addr), 32'h084);
        repeat (10) @(posedge clk);
        #1;
        check("gap_addr_hold", {19'd0, out_ctrl.valid, mem_img_addr}, 32'h084);
        ready = 1'b1;
      end
    join
    check("held_gap_count", 32'(gaps.size()), 32'd1);
    if (gaps.size() > 0) check("held_gap_len", 32'(gaps[0]), 32'd11);

    zero_layer(0, 3);
    zero_layer(3, 0);

    fork
      run_layer(4, 1, 12'h200);
      begin
        repeat (6) @(posedge clk);
        #1 w_img_offset = 12'h7ff; w_img_size = 2; w_in_size = 3; req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
      end
    join

    a0 = ack_count;
    push_layer(4, 2, 12'h300);
    w_img_size = 4; w_in_size = 2; w_img_offset = 12'h300;
    pulse_req();
    repeat (5) @(posedge clk);
    #1 xrst = 1'b1;
    @(posedge clk); #1 xrst = 1'b0;
    q.delete();
    @(negedge clk);
    check("abort_outs", {25'd0, out_ctrl.valid, out_ctrl.start, out_ctrl.stop,
                         first_input, last_input, busy, ack}, 32'd0);
    check("abort_addr", 32'(mem_img_addr), 32'd0);
    repeat (4) @(negedge clk);
    check("abort_no_ack", 32'(ack_count), 32'(a0));
    run_layer(2, 1, 12'h040);

    gaps.delete();
    run_layer(1, 2, 12'hfff);
    check("img1_gap_count", 32'(gaps.size()), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
